vga_sync_monitor: RTL and testbench
===================================

# vga_sync_monitor

Receive-side checker for the VGA timing our display controller generates. It samples `hSync` and `vSync`, both active-low, on the 100 MHz board clock. It measures line period, sync pulse widths, lines per frame and vertical sync width, and runs a lock state machine that reports when the timing matches 640x480@60 within tolerance. It sits beside `vga_top` on the same pins, either in loopback or on an external VGA source, and feeds the SSD and LEDs for bring-up diagnostics.

## Interface

Parameters:
- `H_PERIOD`, default 3200. Expected `ClkPort` cycles per line (800 pixels x 4).
- `H_SYNC`, default 384. Expected `ClkPort` cycles of the hSync low pulse.
- `V_LINES`, default 525. Expected lines per frame.
- `V_SYNC`, default 2. Expected lines with vSync low.
- `TOL`, default 4. Allowed ± cycle error on `H_PERIOD` and `H_SYNC`.
- `LOCK_FRAMES`, default 2. Consecutive good frames required to lock.
- `TIMEOUT`, default 12800. `ClkPort` cycles with no hSync fall before loss is declared.

Ports:
- `ClkPort`, in, 1. 100 MHz board clock. Single clock domain.
- `Reset`, in, 1. Asynchronous, active-high.
- `hSync`, in, 1. Horizontal sync, active-low. May be asynchronous to `ClkPort`.
- `vSync`, in, 1. Vertical sync, active-low. May be asynchronous to `ClkPort`.
- `line_period`, out, 16. Last measured hSync fall-to-fall distance, in cycles.
- `hsync_width`, out, 16. Last measured hSync low width, in cycles.
- `frame_lines`, out, 10. Last measured hSync falls per frame.
- `vsync_lines`, out, 4. Last measured hSync falls during vSync low.
- `line_idx`, out, 10. hSync falls since the last vSync fall. Saturates at 1023.
- `locked`, out, 1. High in LOCKED state only.
- `err_count`, out, 8. Number of lock losses. Saturates at 255.

## Operation

- Input conditioning:
  - `hSync` and `vSync` each pass through a 2-flop synchronizer plus one history flop.
  - fall = history 1, sync 0. rise = history 0, sync 1.
- Horizontal counter `hcnt`, 16 bits, saturating:
  - increments every cycle;
  - on an hSync fall, `line_period <= hcnt` and `hcnt <= 1`.
- `h_valid` is set by the first hSync fall after reset. `line_period` checks apply only while `h_valid` is set.
- Width counter:
  - counts cycles while synced `hSync` is low;
  - on hSync rise, `hsync_width <= count` and the count clears.
- Line counter `lcnt`:
  - increments on each hSync fall;
  - on a vSync fall, `frame_lines <= lcnt`.
  - After a vSync fall with no hSync fall that cycle: `lcnt <= 0`.
  - If an hSync fall and a vSync fall occur in the same cycle, the hSync fall belongs to the new frame: `frame_lines <= lcnt` (excluding that fall) and `lcnt <= 1`.
  - `line_idx` mirrors `lcnt`.
- Vsync line counter:
  - counts hSync falls while synced `vSync` is low, including a fall coincident with the vSync fall;
  - on vSync rise, `vsync_lines <=` count (saturates at 15) and the count clears.
- Violations:
  - H: `line_period` outside `H_PERIOD±TOL` at an hSync fall (only while `h_valid`).
  - W: `hsync_width` outside `H_SYNC±TOL` at an hSync rise.
  - F: at a vSync fall, `frame_lines != V_LINES` or the last `vsync_lines != V_SYNC`.
  - `frame_bad` is set by H or W and cleared at each vSync fall after that fall's evaluation.
- Timeout: `hcnt == TIMEOUT`, which also requires `h_valid` or holds after reset.
- FSM states SEARCH, MEASURE, LOCKED. Reset state is SEARCH.
  - SEARCH, on a vSync fall: go to MEASURE, `good <= 0`. That first frame is partial and is never scored.
  - MEASURE, on a vSync fall:
    - if `frame_bad`, H, W or F: `good <= 0`;
    - otherwise `good++`, and when `good` reaches `LOCK_FRAMES` go to LOCKED.
  - LOCKED, on any H, W or F (W occurring within the frame), or on timeout: go to SEARCH and `err_count++` (saturating).
  - Timeout in MEASURE: go to SEARCH, no `err_count` change.
- Reset mid-operation:
  - all counters, outputs and `h_valid` clear immediately;
  - the next lock requires a fresh vSync fall plus `LOCK_FRAMES` full frames.

## Timing

- Reset values:
  - `line_period`, `hsync_width`, `frame_lines`, `vsync_lines`, `line_idx`, `err_count`: 0.
  - `locked`: 0.
- Latency: a measurement output updates on the 3rd `ClkPort` rising edge after the pin transition is first sampled high/low. The synchronizer latency is constant, so it does not bias measured periods.
- `locked` rises on the cycle after the qualifying vSync fall event. On a violation or timeout it falls on the cycle after the event.
- `err_count` increments on the same edge `locked` falls.
- Only one FSM transition per cycle. Timeout has priority over edge events in the same cycle.

## Test plan

- Reset, then ideal timing (3200-cycle lines, 384-cycle hSync, 525 lines, 2-line vSync) → `locked=1` after the 3rd vSync fall; `line_period=3200`, `hsync_width=384`, `frame_lines=525`, `vsync_lines=2`, `err_count=0`.
- While locked, stretch one line to 3210 cycles → `locked` drops 3 cycles after the late fall, `err_count=1`; relock after 2 further clean full frames.
- While locked, hold `hSync` high → `locked=0` and `err_count` increments exactly when `hcnt` reaches 12800; `line_period` keeps its last value, 3200.
- Drive a 3-line vSync → `vsync_lines=3`, frame rejected at the next vSync fall; with the fault persisting, never locks and `err_count` stays unchanged from MEASURE.
- hSync fall and vSync fall in the same sampled cycle, 525-line frames → `frame_lines=525`, `line_idx=1` the cycle after; lock is achieved normally.
- Assert `Reset` mid-frame while locked → all outputs are 0 asynchronously, including `err_count`; after release, `locked` returns only after 1 partial plus 2 full frames.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures hSync/vSync timing on the board clock
// and reports lock to the expected mode through a SEARCH/MEASURE/LOCKED machine.
module vga_sync_monitor #(
    parameter int H_PERIOD    = 3200,
    parameter int H_SYNC      = 384,
    parameter int V_LINES     = 525,
    parameter int V_SYNC      = 2,
    parameter int TOL         = 4,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 12800
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        hSync,
    input  logic        vSync,
    output logic [15:0] line_period,
    output logic [15:0] hsync_width,
    output logic [9:0]  frame_lines,
    output logic [3:0]  vsync_lines,
    output logic [9:0]  line_idx,
    output logic        locked,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [15:0] HP_MIN    = 16'(H_PERIOD - TOL);
    localparam logic [15:0] HP_MAX    = 16'(H_PERIOD + TOL);
    localparam logic [15:0] HS_MIN    = 16'(H_SYNC - TOL);
    localparam logic [15:0] HS_MAX    = 16'(H_SYNC + TOL);
    localparam logic [15:0] TO_CNT    = 16'(TIMEOUT);
    localparam logic [9:0]  V_LINES_C = 10'(V_LINES);
    localparam logic [3:0]  V_SYNC_C  = 4'(V_SYNC);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

    logic        hs_meta_q, hs_sync_q, hs_hist_q;
    logic        vs_meta_q, vs_sync_q, vs_hist_q;
    logic        h_fall, h_rise, v_fall, v_rise;
    logic [15:0] hcnt_q, hcnt_d, line_period_q, line_period_d;
    logic [15:0] wcnt_q, wcnt_d, hsync_width_q, hsync_width_d;
    logic [9:0]  lcnt_q, lcnt_d, frame_lines_q, frame_lines_d;
    logic [3:0]  vcnt_q, vcnt_d, vsync_lines_q, vsync_lines_d;
    logic        h_valid_q, h_valid_d, frame_bad_q, frame_bad_d;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d, err_q, err_d;
    logic        h_viol, w_viol, f_viol, timeout;

    // Synchronizers idle high so reset never fabricates an edge on a quiet line.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            hs_hist_q <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_hist_q <= 1'b1;
        end else begin
            hs_meta_q <= hSync;
            hs_sync_q <= hs_meta_q;
            hs_hist_q <= hs_sync_q;
            vs_meta_q <= vSync;
            vs_sync_q <= vs_meta_q;
            vs_hist_q <= vs_sync_q;
        end
    end

    assign h_fall = hs_hist_q & ~hs_sync_q;
    assign h_rise = ~hs_hist_q & hs_sync_q;
    assign v_fall = vs_hist_q & ~vs_sync_q;
    assign v_rise = ~vs_hist_q & vs_sync_q;

    always_comb begin
        hcnt_d        = (&hcnt_q) ? hcnt_q : hcnt_q + 16'd1;
        line_period_d = line_period_q;
        h_valid_d     = h_valid_q;
        if (h_fall) begin
            line_period_d = hcnt_q;
            hcnt_d        = 16'd1;
            h_valid_d     = 1'b1;
        end

        wcnt_d        = wcnt_q;
        hsync_width_d = hsync_width_q;
        if (h_rise) begin
            hsync_width_d = wcnt_q;
            wcnt_d        = '0;
        end else if (!hs_sync_q && !(&wcnt_q)) begin
            wcnt_d = wcnt_q + 16'd1;
        end

        // A fall coincident with the vSync fall opens the new frame.
        lcnt_d        = lcnt_q;
        frame_lines_d = frame_lines_q;
        if (v_fall) begin
            frame_lines_d = lcnt_q;
            lcnt_d        = h_fall ? 10'd1 : 10'd0;
        end else if (h_fall && !(&lcnt_q)) begin
            lcnt_d = lcnt_q + 10'd1;
        end

        vcnt_d        = vcnt_q;
        vsync_lines_d = vsync_lines_q;
        if (v_rise) begin
            vsync_lines_d = vcnt_q;
            vcnt_d        = '0;
        end else if (h_fall && !vs_sync_q && !(&vcnt_q)) begin
            vcnt_d = vcnt_q + 4'd1;
        end
    end

    assign h_viol  = h_fall & h_valid_q & ((hcnt_q < HP_MIN) | (hcnt_q > HP_MAX));
    assign w_viol  = h_rise & ((wcnt_q < HS_MIN) | (wcnt_q > HS_MAX));
    assign f_viol  = v_fall & ((lcnt_q != V_LINES_C) | (vsync_lines_q != V_SYNC_C));
    assign timeout = (hcnt_q == TO_CNT);

    always_comb begin
        frame_bad_d = v_fall ? 1'b0 : (frame_bad_q | h_viol | w_viol);
        state_d     = state_q;
        good_d      = good_q;
        err_d       = err_q;
        if (timeout) begin
            if (state_q == LOCKED && err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (v_fall) begin
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                MEASURE: begin
                    if (v_fall) begin
                        if (frame_bad_q | h_viol | w_viol | f_viol) begin
                            good_d = '0;
                        end else begin
                            good_d = good_q + 8'd1;
                            if (good_q + 8'd1 >= LOCK_N) state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (h_viol | w_viol | f_viol) begin
                        state_d = SEARCH;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hcnt_q        <= '0;
            line_period_q <= '0;
            h_valid_q     <= 1'b0;
            wcnt_q        <= '0;
            hsync_width_q <= '0;
            lcnt_q        <= '0;
            frame_lines_q <= '0;
            vcnt_q        <= '0;
            vsync_lines_q <= '0;
            frame_bad_q   <= 1'b0;
            state_q       <= SEARCH;
            good_q        <= '0;
            err_q         <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            line_period_q <= line_period_d;
            h_valid_q     <= h_valid_d;
            wcnt_q        <= wcnt_d;
            hsync_width_q <= hsync_width_d;
            lcnt_q        <= lcnt_d;
            frame_lines_q <= frame_lines_d;
            vcnt_q        <= vcnt_d;
            vsync_lines_q <= vsync_lines_d;
            frame_bad_q   <= frame_bad_d;
            state_q       <= state_d;
            good_q        <= good_d;
            err_q         <= err_d;
        end
    end

    assign line_period = line_period_q;
    assign hsync_width = hsync_width_q;
    assign frame_lines = frame_lines_q;
    assign vsync_lines = vsync_lines_q;
    assign line_idx    = lcnt_q;
    assign locked      = (state_q == LOCKED);
    assign err_count   = err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: scaled-down timing, pixel-level sync generator and a
// timestamp-based reference model compared against every output on every cycle.
module tb_vga_sync_monitor;

    localparam int P_HP  = 64;
    localparam int P_HS  = 8;
    localparam int P_VL  = 12;
    localparam int P_VS  = 2;
    localparam int P_TOL = 2;
    localparam int P_LF  = 2;
    localparam int P_TO  = 256;
    localparam int VST   = 2;

    logic        ClkPort = 1'b0;
    logic        Reset;
    logic        hSync, vSync;
    logic [15:0] line_period, hsync_width;
    logic [9:0]  frame_lines, line_idx;
    logic [3:0]  vsync_lines;
    logic        locked;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_now, m_hbase, m_tfall, m_lines, m_vcnt, m_state, m_good;
    bit m_hvalid, m_fbad;
    bit mh [3];
    bit mv [3];
    int e_lp, e_hw, e_fl, e_vl, e_err;
    bit e_locked;

    vga_sync_monitor #(
        .H_PERIOD(P_HP), .H_SYNC(P_HS), .V_LINES(P_VL), .V_SYNC(P_VS),
        .TOL(P_TOL), .LOCK_FRAMES(P_LF), .TIMEOUT(P_TO)
    ) dut (
        .ClkPort(ClkPort), .Reset(Reset), .hSync(hSync), .vSync(vSync),
        .line_period(line_period), .hsync_width(hsync_width),
        .frame_lines(frame_lines), .vsync_lines(vsync_lines),
        .line_idx(line_idx), .locked(locked), .err_count(err_count)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic model_reset();
        m_now = 0; m_hbase = 0; m_tfall = 0; m_lines = 0; m_vcnt = 0;
        m_state = 0; m_good = 0; m_hvalid = 0; m_fbad = 0;
        e_lp = 0; e_hw = 0; e_fl = 0; e_vl = 0; e_err = 0; e_locked = 0;
        for (int i = 0; i < 3; i++) begin mh[i] = 1; mv[i] = 1; end
    endtask

    // Model state: mh/mv = {first, second, third} samples of each pin; times are cycle stamps.
    task automatic model_step();
        int hc, wd;
        bit hf, hr, vf, vr, bad_h, bad_w, bad_f, to;
        hf = mh[2] && !mh[1];
        hr = !mh[2] && mh[1];
        vf = mv[2] && !mv[1];
        vr = !mv[2] && mv[1];
        hc = m_now - m_hbase;  if (hc > 65535) hc = 65535;
        wd = m_now - m_tfall;  if (wd > 65535) wd = 65535;
        bad_h = hf && m_hvalid && (hc < P_HP - P_TOL || hc > P_HP + P_TOL);
        bad_w = hr && (wd < P_HS - P_TOL || wd > P_HS + P_TOL);
        bad_f = vf && (m_lines != P_VL || e_vl != P_VS);
        to    = (hc == P_TO);
        if (to) begin
            if (m_state == 2 && e_err < 255) e_err++;
            m_state = 0;
        end else if (m_state == 0) begin
            if (vf) begin m_state = 1; m_good = 0; end
        end else if (m_state == 1) begin
            if (vf) begin
                if (m_fbad || bad_h || bad_w || bad_f) m_good = 0;
                else begin
                    m_good++;
                    if (m_good >= P_LF) m_state = 2;
                end
            end
        end else if (bad_h || bad_w || bad_f) begin
            m_state = 0;
            if (e_err < 255) e_err++;
        end
        e_locked = (m_state == 2);
        if (hf) begin e_lp = hc; m_hbase = m_now; m_hvalid = 1; m_tfall = m_now; end
        if (hr) e_hw = wd;
        if (vr) begin e_vl = (m_vcnt > 15) ? 15 : m_vcnt; m_vcnt = 0; end
        else if (hf && !mv[1]) m_vcnt++;
        if (vf) begin e_fl = m_lines; m_lines = hf ? 1 : 0; end
        else if (hf && m_lines < 1023) m_lines++;
        if (vf) m_fbad = 0; else if (bad_h || bad_w) m_fbad = 1;
        mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = hSync;
        mv[2] = mv[1]; mv[1] = mv[0]; mv[0] = vSync;
        m_now++;
    endtask

    always @(posedge ClkPort) begin
        if (Reset) model_reset();
        else model_step();
    end

    always @(negedge ClkPort) begin
        if (chk_en) begin
            checks++;
            if ({line_period, hsync_width, frame_lines, vsync_lines, line_idx, locked, err_count} !==
                {16'(e_lp), 16'(e_hw), 10'(e_fl), 4'(e_vl), 10'(m_lines), e_locked, 8'(e_err)}) begin
                errors++;
                $display("FAIL outputs @%0t: got lp=%0d hw=%0d fl=%0d vl=%0d idx=%0d lk=%0d err=%0d, expected lp=%0d hw=%0d fl=%0d vl=%0d idx=%0d lk=%0d err=%0d",
                         $time, line_period, hsync_width, frame_lines, vsync_lines, line_idx, locked, err_count,
                         e_lp, e_hw, e_fl, e_vl, m_lines, e_locked, e_err);
                if (errors >= 50) begin
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $finish;
                end
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic run_frame(input int nl, input int vs_len, input int voff, input bit jit,
                             input int bad_line, input int bad_per, input int bad_hw, input int stop_line);
        for (int ln = 0; ln < nl && ln < stop_line; ln++) begin
            int per, hw;
            bit vlow;
            per = P_HP;
            hw  = P_HS;
            if (jit) begin
                per = P_HP - P_TOL + int'($urandom_range(0, 2 * P_TOL));
                hw  = P_HS - P_TOL + int'($urandom_range(0, 2 * P_TOL));
            end
            if (ln == bad_line) begin per = bad_per; hw = bad_hw; end
            for (int x = 0; x < per; x++) begin
                @(negedge ClkPort);
                hSync = (x >= hw);
                vlow  = (ln > VST || (ln == VST && x >= voff)) &&
                        (ln < VST + vs_len || (ln == VST + vs_len && x < voff));
                vSync = !vlow;
            end
        end
    endtask

    function automatic int rvoff();
        return int'($urandom_range(0, P_HP - P_TOL - 2));
    endfunction

    task automatic clean_frames(input int n, input int vs_len, input int voff);
        for (int f = 0; f < n; f++) run_frame(P_VL, vs_len, voff, 0, -1, P_HP, P_HS, P_VL);
    endtask

    task automatic check_all_zero(input string tag);
        check_lit({tag, " line_period"}, int'(line_period), 0);
        check_lit({tag, " hsync_width"}, int'(hsync_width), 0);
        check_lit({tag, " frame_lines"}, int'(frame_lines), 0);
        check_lit({tag, " vsync_lines"}, int'(vsync_lines), 0);
        check_lit({tag, " line_idx"}, int'(line_idx), 0);
        check_lit({tag, " locked"}, int'(locked), 0);
        check_lit({tag, " err_count"}, int'(err_count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; hSync = 1'b1; vSync = 1'b1;
        model_reset();
        repeat (3) @(negedge ClkPort);
        check_all_zero("reset");
        chk_en = 1'b1;
        Reset  = 1'b0;

        // Ideal timing: lock on the third vSync fall.
        clean_frames(4, P_VS, rvoff());
        check_lit("ideal locked", int'(locked), 1);
        check_lit("ideal line_period", int'(line_period), P_HP);
        check_lit("ideal hsync_width", int'(hsync_width), P_HS);
        check_lit("ideal frame_lines", int'(frame_lines), P_VL);
        check_lit("ideal vsync_lines", int'(vsync_lines), P_VS);
        check_lit("ideal err_count", int'(err_count), 0);

        // One stretched line while locked, then relock.
        run_frame(P_VL, P_VS, rvoff(), 0, 5, P_HP + 10, P_HS, P_VL);
        check_lit("stretch locked", int'(locked), 0);
        check_lit("stretch err_count", int'(err_count), 1);
        clean_frames(3, P_VS, rvoff());
        check_lit("relock locked", int'(locked), 1);

        // hSync stuck high while locked.
        for (int i = 0; i < P_TO + 50; i++) begin
            @(negedge ClkPort);
            hSync = 1'b1; vSync = 1'b1;
        end
        check_lit("timeout locked", int'(locked), 0);
        check_lit("timeout err_count", int'(err_count), 2);
        check_lit("timeout line_period", int'(line_period), P_HP);

        // Three-line vSync keeps every frame rejected.
        clean_frames(4, 3, rvoff());
        check_lit("vs3 vsync_lines", int'(vsync_lines), 3);
        check_lit("vs3 locked", int'(locked), 0);
        check_lit("vs3 err_count", int'(err_count), 2);

        // hSync and vSync falling in the same cycle.
        clean_frames(4, P_VS, 0);
        check_lit("coincident frame_lines", int'(frame_lines), P_VL);
        check_lit("coincident locked", int'(locked), 1);

        // Randomized jitter, faults, frame lengths and vSync widths.
        for (int f = 0; f < 8; f++) begin
            int bl, bp, bw, nl, vl;
            bl = -1; bp = P_HP; bw = P_HS;
            if ($urandom_range(0, 2) == 0) begin
                bl = int'($urandom_range(0, P_VL - 1));
                if ($urandom_range(0, 1) == 0)
                    bp = ($urandom_range(0, 1) == 0) ? P_HP + P_TOL + 1 + int'($urandom_range(0, 3))
                                                      : P_HP - P_TOL - 1 - int'($urandom_range(0, 3));
                else
                    bw = ($urandom_range(0, 1) == 0) ? P_HS + P_TOL + 1 : P_HS - P_TOL - 1;
            end
            nl = ($urandom_range(0, 5) == 0) ? P_VL + 1 : P_VL;
            vl = ($urandom_range(0, 4) == 0) ? 3 : P_VS;
            run_frame(nl, vl, rvoff(), 1, bl, bp, bw, nl);
        end

        // Reset mid-frame while locked.
        clean_frames(3, P_VS, rvoff());
        run_frame(P_VL, P_VS, rvoff(), 0, -1, P_HP, P_HS, 6);
        check_lit("pre-reset locked", int'(locked), 1);
        @(negedge ClkPort);
        #2 Reset = 1'b1; hSync = 1'b1; vSync = 1'b1;
        #1 check_all_zero("async reset");
        repeat (3) @(negedge ClkPort);
        Reset = 1'b0;
        clean_frames(2, P_VS, rvoff());
        check_lit("post-reset 2 frames locked", int'(locked), 0);
        clean_frames(1, P_VS, rvoff());
        check_lit("post-reset 3 frames locked", int'(locked), 1);
        check_lit("post-reset err_count", int'(err_count), 0);

        repeat (2) @(negedge ClkPort);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
